// File: rtl/pixel_scan_if.sv
// Control, configuration and position bundle between a pixel consumer and pixel_scan_gen.
interface pixel_scan_if #(
    parameter int unsigned X_MAX = 64,
    parameter int unsigned Y_MAX = 64,
    parameter int unsigned BW    = 3
);
    localparam int unsigned CX = $clog2(X_MAX);
    localparam int unsigned CY = $clog2(Y_MAX);
    localparam int unsigned SX = $clog2(X_MAX + 1);
    localparam int unsigned SY = $clog2(Y_MAX + 1);

    logic          start;
    logic          abort;
    logic          advance;
    logic          serp;
    logic [SX-1:0] max_x;
    logic [SY-1:0] max_y;
    logic [BW-1:0] border;
    logic [CX-1:0] curr_x;
    logic [CY-1:0] curr_y;
    logic          pos_valid;
    logic [1:0]    next_dir;
    logic          end_pos;
    logic          done;
    logic          cfg_err;

    // Consumer side: issues commands and configuration, observes positions.
    modport master (
        output start, abort, advance, serp, max_x, max_y, border,
        input  curr_x, curr_y, pos_valid, next_dir, end_pos, done, cfg_err
    );

    // Generator side.
    modport slave (
        input  start, abort, advance, serp, max_x, max_y, border,
        output curr_x, curr_y, pos_valid, next_dir, end_pos, done, cfg_err
    );
endinterface

// File: rtl/pixel_scan_gen.sv
// Pixel-position generator: walks the image minus a border in raster or serpentine order.
module pixel_scan_gen #(
    parameter int unsigned X_MAX = 64,
    parameter int unsigned Y_MAX = 64,
    parameter int unsigned BW    = 3
) (
    input  logic          clk,
    input  logic          n_rst,
    pixel_scan_if.slave   bus
);
    localparam int unsigned CX = $clog2(X_MAX);
    localparam int unsigned CY = $clog2(Y_MAX);
    localparam int unsigned SX = $clog2(X_MAX + 1);
    localparam int unsigned SY = $clog2(Y_MAX + 1);
    localparam int unsigned XW = SX + 1;
    localparam int unsigned YW = SY + 1;
    localparam int unsigned SW = (XW > YW) ? XW : YW;
    // Wide enough to hold either size and 2*border+1 without wrap.
    localparam int unsigned LW = ((SW > BW + 1) ? SW : BW + 1) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CX-1:0] x_q, x_d, x_lo_q, x_lo_d, x_hi_q, x_hi_d;
    logic [CY-1:0] y_q, y_d, y_lo_q, y_lo_d, y_hi_q, y_hi_d;
    logic          dir_q, dir_d;
    logic          serp_q, serp_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;

    logic          in_scan;
    logic          row_end;
    logic          last_pos;
    logic          row_step;
    logic          dir_after;
    logic          cfg_bad;

    // Position classification from registered state; drives next_dir/end_pos.
    assign in_scan   = (state_q == SCAN);
    assign row_end   = dir_q ? (x_q == x_hi_q) : (x_q == x_lo_q);
    assign last_pos  = in_scan && row_end && (y_q == y_hi_q);
    assign row_step  = in_scan && row_end && !last_pos;
    assign dir_after = (row_step && serp_q) ? !dir_q : dir_q;

    // Configuration legality: size limits and a non-empty region on both axes.
    assign cfg_bad = (LW'(bus.max_x) > LW'(X_MAX))
                  || (LW'(bus.max_y) > LW'(Y_MAX))
                  || (LW'(bus.max_x) < ((LW'(bus.border) << 1) + LW'(1)))
                  || (LW'(bus.max_y) < ((LW'(bus.border) << 1) + LW'(1)));

    // Next-state: abort beats start, start beats advance.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        serp_d    = serp_q;
        x_lo_d    = x_lo_q;
        x_hi_d    = x_hi_q;
        y_lo_d    = y_lo_q;
        y_hi_d    = y_hi_q;
        done_d    = 1'b0;
        cfg_err_d = cfg_err_q;

        if (bus.abort) begin
            state_d = IDLE;
        end else if (bus.start) begin
            cfg_err_d = cfg_bad;
            if (cfg_bad) begin
                state_d = IDLE;
            end else begin
                state_d = SCAN;
                x_lo_d  = CX'(bus.border);
                y_lo_d  = CY'(bus.border);
                x_hi_d  = CX'(XW'(bus.max_x) - XW'(1) - XW'(bus.border));
                y_hi_d  = CY'(YW'(bus.max_y) - YW'(1) - YW'(bus.border));
                x_d     = CX'(bus.border);
                y_d     = CY'(bus.border);
                dir_d   = 1'b1;
                serp_d  = bus.serp;
            end
        end else if (in_scan && bus.advance) begin
            if (last_pos) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (row_end) begin
                y_d   = y_q + CY'(1);
                dir_d = dir_after;
                if (!serp_q) begin
                    x_d = x_lo_q;
                end
            end else if (dir_q) begin
                x_d = x_q + CX'(1);
            end else begin
                x_d = x_q - CX'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            dir_q     <= 1'b0;
            serp_q    <= 1'b0;
            x_lo_q    <= '0;
            x_hi_q    <= '0;
            y_lo_q    <= '0;
            y_hi_q    <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            serp_q    <= serp_d;
            x_lo_q    <= x_lo_d;
            x_hi_q    <= x_hi_d;
            y_lo_q    <= y_lo_d;
            y_hi_q    <= y_hi_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.curr_x    = x_q;
    assign bus.curr_y    = y_q;
    assign bus.pos_valid = in_scan;
    assign bus.end_pos   = last_pos;
    assign bus.next_dir  = {row_step, in_scan & dir_after};
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_pixel_scan_gen.sv
// Scoreboard bench for pixel_scan_gen: directed test-plan scenarios followed by random traffic.
module tb_pixel_scan_gen;
    localparam int unsigned X_MAX = 64;
    localparam int unsigned Y_MAX = 64;
    localparam int unsigned BW    = 3;
    localparam int unsigned SX    = $clog2(X_MAX + 1);
    localparam int unsigned SY    = $clog2(Y_MAX + 1);

    typedef struct {
        int tag;
        int x;
        int y;
        int endp;
        int dir;
    } pos_t;

    typedef struct {
        int tag;
        int err;
    } cfg_t;

    logic clk;
    logic n_rst;

    pixel_scan_if #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .BW(BW)) bus ();

    pixel_scan_gen #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .BW(BW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: the full ordered position list of the active scan.
    pos_t pl[$];
    int   pi;
    bit   active;

    // Scoreboard queues, tagged with the cycle in which the DUT must show them.
    pos_t pos_q[$];
    int   done_q[$];
    cfg_t cfg_q[$];
    int   exp_cfg;
    pos_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Enumerate the region row by row; serpentine reverses every odd row.
    function automatic void build_list(bit sp, int mx, int my, int bd);
        int x_lo = bd;
        int x_hi = mx - 1 - bd;
        int y_lo = bd;
        int nx   = x_hi - x_lo + 1;
        int ny   = (my - 1 - bd) - y_lo + 1;
        pl.delete();
        for (int r = 0; r < ny; r++) begin
            bit inc = !sp || (r % 2 == 0);
            for (int k = 0; k < nx; k++) begin
                pos_t p;
                bit   last_in_row = (k == nx - 1);
                bit   fin         = last_in_row && (r == ny - 1);
                bit   step        = last_in_row && !fin;
                p.tag  = 0;
                p.x    = inc ? x_lo + k : x_hi - k;
                p.y    = y_lo + r;
                p.endp = fin ? 1 : 0;
                p.dir  = (step ? 2 : 0) + (((step && sp) ? !inc : inc) ? 1 : 0);
                pl.push_back(p);
            end
        end
    endfunction

    // Apply one cycle of inputs to the model and queue what the DUT must show next cycle.
    function automatic void model_step(bit st, bit ab, bit adv, bit sp, int mx, int my, int bd);
        int tag = cyc + 1;
        if (ab) begin
            active = 0;
        end else if (st) begin
            bit   bad = (mx > int'(X_MAX)) || (my > int'(Y_MAX)) ||
                        (mx < 2 * bd + 1) || (my < 2 * bd + 1);
            cfg_t c;
            c.tag = tag;
            c.err = bad ? 1 : 0;
            cfg_q.push_back(c);
            if (bad) begin
                active = 0;
            end else begin
                build_list(sp, mx, my, bd);
                pi     = 0;
                active = 1;
            end
        end else if (active && adv) begin
            if (pi == pl.size() - 1) begin
                active = 0;
                done_q.push_back(tag);
            end else begin
                pi++;
            end
        end
        if (active) begin
            pos_t p = pl[pi];
            p.tag = tag;
            pos_q.push_back(p);
        end
    endfunction

    task automatic cyc_drive(input bit st, input bit ab, input bit adv, input bit sp,
                             input int mx, input int my, input int bd);
        bus.start   = st;
        bus.abort   = ab;
        bus.advance = adv;
        bus.serp    = sp;
        bus.max_x   = SX'(mx);
        bus.max_y   = SY'(my);
        bus.border  = BW'(bd);
        model_step(st, ab, adv, sp, mx, my, bd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pos_valid"}, int'(bus.pos_valid), 0);
        check({tag, "_curr_x"},    int'(bus.curr_x),    0);
        check({tag, "_curr_y"},    int'(bus.curr_y),    0);
        check({tag, "_next_dir"},  int'(bus.next_dir),  0);
        check({tag, "_end_pos"},   int'(bus.end_pos),   0);
        check({tag, "_done"},      int'(bus.done),      0);
        check({tag, "_cfg_err"},   int'(bus.cfg_err),   0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next clock edge.
    task automatic do_reset();
        #1;
        n_rst = 1'b0;
        #1;
        check_all_zero("rst");
        pos_q.delete();
        done_q.delete();
        cfg_q.delete();
        active      = 0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.advance = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (!n_rst) begin
            exp_cfg = 0;
        end else begin
            if (bus.pos_valid) begin
                if (pos_q.size() == 0) begin
                    check("pos_unexpected", 1, 0);
                end else begin
                    mon_e = pos_q.pop_front();
                    check("pos_cycle", cyc, mon_e.tag);
                    check("curr_x",   int'(bus.curr_x),   mon_e.x);
                    check("curr_y",   int'(bus.curr_y),   mon_e.y);
                    check("end_pos",  int'(bus.end_pos),  mon_e.endp);
                    check("next_dir", int'(bus.next_dir), mon_e.dir);
                end
            end else begin
                check("idle_end_pos",  int'(bus.end_pos),  0);
                check("idle_next_dir", int'(bus.next_dir), 0);
                if (pos_q.size() > 0 && pos_q[0].tag <= cyc) begin
                    void'(pos_q.pop_front());
                    check("pos_valid_missing", 0, 1);
                end
            end
            if (done_q.size() > 0 && done_q[0] <= cyc) begin
                void'(done_q.pop_front());
                check("done", int'(bus.done), 1);
            end else begin
                check("done", int'(bus.done), 0);
            end
            while (cfg_q.size() > 0 && cfg_q[0].tag <= cyc) begin
                exp_cfg = cfg_q[0].err;
                void'(cfg_q.pop_front());
            end
            check("cfg_err", int'(bus.cfg_err), exp_cfg);
        end
    end

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.advance = 1'b0;
        bus.serp    = 1'b0;
        bus.max_x   = '0;
        bus.max_y   = '0;
        bus.border  = '0;
        active      = 0;
        pi          = 0;
        n_rst       = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Serpentine 4x3, border 0, advance held.
        cyc_drive(1, 0, 0, 1, 4, 3, 0);
        repeat (12) cyc_drive(0, 0, 1, 1, 4, 3, 0);
        idle(2);

        // Raster 6x5, border 1.
        cyc_drive(1, 0, 0, 0, 6, 5, 1);
        repeat (12) cyc_drive(0, 0, 1, 0, 6, 5, 1);
        idle(2);

        // Illegal configurations and recovery.
        cyc_drive(1, 0, 0, 0, 6, 6, 3);
        idle(2);
        cyc_drive(1, 0, 0, 0, 4, 3, 0);
        cyc_drive(0, 1, 0, 0, 0, 0, 0);
        cyc_drive(1, 0, 0, 0, X_MAX + 1, 4, 0);
        idle(2);

        // Single-pixel region.
        cyc_drive(1, 0, 0, 1, 7, 7, 3);
        cyc_drive(0, 0, 1, 1, 7, 7, 3);
        idle(2);

        // Single-column serpentine region.
        cyc_drive(1, 0, 0, 1, 3, 6, 1);
        repeat (4) cyc_drive(0, 0, 1, 1, 3, 6, 1);
        idle(1);

        // Abort at (2,1), restart mid-scan, start+abort together.
        cyc_drive(1, 0, 0, 1, 4, 3, 0);
        repeat (5) cyc_drive(0, 0, 1, 1, 4, 3, 0);
        cyc_drive(0, 1, 1, 1, 4, 3, 0);
        idle(2);
        cyc_drive(1, 0, 0, 1, 4, 3, 0);
        repeat (3) cyc_drive(0, 0, 1, 1, 4, 3, 0);
        cyc_drive(1, 0, 1, 0, 6, 5, 1);
        repeat (2) cyc_drive(0, 0, 1, 0, 6, 5, 1);
        cyc_drive(1, 1, 1, 0, 8, 8, 0);
        idle(2);

        // Stall holds position, then reset mid-scan.
        cyc_drive(1, 0, 0, 0, 4, 3, 0);
        cyc_drive(0, 0, 1, 0, 4, 3, 0);
        repeat (5) cyc_drive(0, 0, 0, 0, 4, 3, 0);
        repeat (2) cyc_drive(0, 0, 1, 0, 4, 3, 0);
        do_reset();
        idle(2);

        // Random traffic.
        for (int i = 0; i < 5000; i++) begin
            bit st;
            bit ab;
            bit adv;
            bit sp;
            int mx;
            int my;
            int bd;
            st  = active ? ($urandom_range(99) < 2) : ($urandom_range(99) < 40);
            ab  = ($urandom_range(99) < 2);
            adv = ($urandom_range(99) < 75);
            sp  = ($urandom_range(1) == 1);
            mx  = int'($urandom_range(X_MAX + 2));
            my  = int'($urandom_range(16));
            bd  = ($urandom_range(9) == 0) ? int'($urandom_range(7)) : int'($urandom_range(2));
            if ($urandom_range(49) == 0) my = int'($urandom_range(Y_MAX + 2));
            cyc_drive(st, ab, adv, sp, mx, my, bd);
        end

        cyc_drive(0, 1, 0, 0, 0, 0, 0);
        idle(3);
        check("queues_drained", pos_q.size() + done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pixel_scan_gen.md
# pixel_scan_gen

Parametrised pixel-position generator for the corner-detector front end. It walks a configurable region of interest: the image minus a programmable border, in either raster or serpentine (boustrophedon) order. It issues one coordinate per `advance` handshake and flags the last pixel and the row steps. It replaces the fixed serpentine scanner and adds border cropping, mode selection, abort/restart, configuration checking and a completion pulse.

## Interface
- `X_MAX`, default 64: largest supported image width. `CX = $clog2(X_MAX)` is the coordinate width and `SX = $clog2(X_MAX+1)` is the size width.
- `Y_MAX`, default 64: largest supported image height. `CY` and `SY` are defined the same way.
- `BW`, default 3: width of the border field.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  latch the configuration and begin a scan. Legal in any state.
- `abort`  in  1  end the scan immediately, with no `done`.
- `advance`  in  1  consume the current position. Ignored unless `pos_valid` is 1.
- `serp`  in  1  scan order: 1 = serpentine, 0 = raster. Sampled only on `start`.
- `max_x`  in  SX  image width in pixels. Sampled on `start`.
- `max_y`  in  SY  image height in pixels. Sampled on `start`.
- `border`  in  BW  margin in pixels, applied on all four sides. Sampled on `start`.
- `curr_x`  out  CX  current column.
- `curr_y`  out  CY  current row.
- `pos_valid`  out  1  `curr_x`/`curr_y` hold a valid region position.
- `next_dir`  out  2  describes the next `advance`:
  - bit1 = 1 when it steps y.
  - bit0 = x travel direction after it (1 = increasing).
- `end_pos`  out  1  current position is the final one. Only ever 1 while `pos_valid` is 1.
- `done`  out  1  one-cycle pulse, registered, after the final position is consumed.
- `cfg_err`  out  1  the last `start` carried an illegal configuration. Held until the next `start`.

## Operation
- Region bounds are computed at `start` with SX+1 / SY+1 bit unsigned arithmetic and registered:
  - `x_lo = border`, `x_hi = max_x - 1 - border`.
  - `y_lo = border`, `y_hi = max_y - 1 - border`.
- The configuration is illegal if any of these hold: `max_x > X_MAX`, `max_y > Y_MAX`, `max_x < 2*border+1`, `max_y < 2*border+1`. Zero sizes are therefore illegal.
- FSM states are IDLE and SCAN.
  - **IDLE:** `pos_valid = 0`. A legal `start` sets `cfg_err` to 0 and moves to SCAN at `(x_lo, y_lo)` with direction increasing. An illegal `start` sets `cfg_err` to 1 and stays in IDLE.
  - **SCAN:** `pos_valid = 1`.
    - `advance` when not at row end: x moves one step in the current direction.
    - `advance` at row end, raster mode: x goes to `x_lo`, y increments, direction stays increasing.
    - `advance` at row end, serpentine mode: x holds, y increments, direction toggles.
    - `advance` while `end_pos` is 1: go to IDLE and pulse `done` in the next cycle.
- Row end is `x == x_hi` when the direction is increasing, and `x == x_lo` when it is decreasing.
- `end_pos` = row end && `y == y_hi`.
- `next_dir`:
  - bit1 = row end && !`end_pos`.
  - bit0 = the direction that will apply after the advance: toggled on serpentine row steps, unchanged otherwise.
  - Both bits are 0 in IDLE.
- Single-column region (`x_lo == x_hi`): every advance is a row step. In serpentine mode the direction still toggles; x is unchanged.
- Priority: `abort` > `start` > `advance`.
  - `start` in SCAN restarts from the new configuration. No `done` is issued.
  - `abort` in SCAN returns to IDLE. No `done` is issued.
- In IDLE, `curr_x`/`curr_y` hold their last value.

## Timing
- Reset values:
  - State = IDLE.
  - `curr_x`, `curr_y`, `pos_valid`, `next_dir`, `end_pos`, `done`, `cfg_err` are all 0.
  - Internal bounds are 0.
- Reset takes effect immediately, including mid-scan. No `done` is produced.
- Latency of `start` to first position: 1 cycle. `start` in cycle N gives `pos_valid = 1` with `(x_lo, y_lo)` in cycle N+1.
- Latency of `advance` to next position: 1 cycle. One position per cycle is sustainable when `advance` is held high.
- Final advance in cycle N: `pos_valid = 0` and `done = 1` in cycle N+1, then `done = 0` in N+2.
- `cfg_err` updates in the cycle after `start`.
- `next_dir` and `end_pos` are combinational from registered state and stable for the whole cycle.

## Test plan
- **Serpentine 4×3, border 0:**
  - Stimulus: `serp=1`, `max_x=4`, `max_y=3`, `border=0`, `advance` held high.
  - Sequence: (0,0)(1,0)(2,0)(3,0)(3,1)(2,1)(1,1)(0,1)(0,2)…(3,2).
  - `next_dir=2'b10` at (3,0), `2'b11` at (0,1).
  - `end_pos` at (3,2); `done` one cycle after its advance.
- **Raster 6×5, border 1:**
  - 12 positions: x 1..4, y 1..3.
  - At (4,1), `next_dir=2'b11`, then (1,2) follows.
  - `done` after the 12th advance.
- **Illegal configurations:**
  - `max_x=6`, `border=3` gives `cfg_err=1` and `pos_valid` stays 0.
  - A following legal `start` clears `cfg_err`.
  - `max_x = X_MAX+1` also gives `cfg_err=1`.
- **Single pixel:**
  - `max_x=7`, `max_y=7`, `border=3` gives (3,3) with `end_pos=1` in the first valid cycle.
  - One advance gives `done`.
- **Abort and restart:**
  - `abort` at (2,1) gives `pos_valid=0` next cycle and no `done`.
  - `start` mid-scan restarts at the new `(x_lo, y_lo)`.
  - `start` and `abort` in the same cycle gives IDLE.
- **Stalls and reset:**
  - `advance` low for 5 cycles holds the position.
  - `n_rst` asserted mid-scan clears all outputs to 0 asynchronously.
